// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-memory access controller.
package mips_mem_pkg;

    // Memory operation codes from the execute stage; codes not listed are reserved.
    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_LWL = 4'd5,
        OP_LWR = 4'd6,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10
    } mem_op_t;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } ctrl_state_t;

    // Reads always fetch the whole word.
    localparam logic [3:0] BE_ALL = 4'b1111;

    function automatic logic is_load(input mem_op_t op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: selects, extends or merges read data into the
// value written back to rt/rd, including the unaligned LWL/LWR merges.
module load_align
    import mips_mem_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  off,
    input  logic [31:0] rd,
    input  logic [31:0] rt_old,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword and build the result for the operation.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path can leave it unassigned and infer a latch.
        result   = rd;
        byte_sel = rd[{off, 3'b000} +: 8];
        half_sel = off[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: result = {24'h0, byte_sel};
            OP_LH:  result = {{16{half_sel[15]}}, half_sel};
            OP_LHU: result = {16'h0, half_sel};
            OP_LWL: begin
                case (off)
                    2'd0:    result = {rd[7:0],  rt_old[23:0]};
                    2'd1:    result = {rd[15:0], rt_old[15:0]};
                    2'd2:    result = {rd[23:0], rt_old[7:0]};
                    default: result = rd;
                endcase
            end
            OP_LWR: begin
                case (off)
                    2'd0:    result = rd;
                    2'd1:    result = {rt_old[31:24], rd[31:8]};
                    2'd2:    result = {rt_old[31:16], rd[31:16]};
                    default: result = {rt_old[31:8],  rd[31:24]};
                endcase
            end
            default: result = rd;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store controller between the MIPS pipeline and an
// Avalon-style data bus: one operation at a time, stalls the core until done.
module mem_access_ctrl
    import mips_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_store_data,
    input  logic [31:0] req_rt_old,
    output logic        req_ready,
    output logic        stall,
    output logic        rsp_valid,
    output logic        rsp_wen,
    output logic [31:0] rsp_wdata,
    output logic        rsp_fault,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    ctrl_state_t state;
    mem_op_t     op_in;
    logic [1:0]  off_in;
    logic        misaligned_in;
    logic        fault_in;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    // Operation context held across the bus access.
    mem_op_t     op_q;
    logic [1:0]  off_q;
    logic [31:0] rt_old_q;
    logic [31:0] load_result;

    assign op_in  = mem_op_t'(req_op);
    assign off_in = req_addr[1:0];

    // The core freezes from the accept cycle through the response cycle.
    assign stall = (state != ST_IDLE) || req_valid;

    // Classify the incoming request: natural-alignment violations and reserved codes fault.
    always_comb begin
        misaligned_in = 1'b0;
        case (op_in)
            OP_LH, OP_LHU, OP_SH: misaligned_in = off_in[0];
            OP_LW, OP_SW:         misaligned_in = (off_in != 2'b00);
            default:              misaligned_in = 1'b0;
        endcase
        fault_in = misaligned_in || !(is_load(op_in) || is_store(op_in));
    end

    // Steer store data onto the addressed byte lanes; loads read the full word.
    always_comb begin
        st_be    = BE_ALL;
        st_wdata = req_store_data;
        case (op_in)
            OP_SB: begin
                st_be    = 4'b0001 << off_in;
                st_wdata = {4{req_store_data[7:0]}};
            end
            OP_SH: begin
                st_be    = off_in[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{req_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .op     (op_q),
        .off    (off_q),
        .rd     (avm_readdata),
        .rt_old (rt_old_q),
        .result (load_result)
    );

    // Control FSM with all bus and response outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // register samples pre-edge values regardless of statement order.
            state          <= ST_IDLE;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_wen        <= 1'b0;
            rsp_fault      <= 1'b0;
            rsp_wdata      <= 32'h0;
            avm_address    <= 32'h0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= 4'h0;
            avm_writedata  <= 32'h0;
            op_q           <= OP_LB;
            off_q          <= 2'd0;
            rt_old_q       <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        op_q      <= op_in;
                        off_q     <= off_in;
                        rt_old_q  <= req_rt_old;
                        if (fault_in) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                            rsp_wen   <= 1'b0;
                            rsp_wdata <= 32'h0;
                        end else begin
                            state          <= ST_BUS;
                            avm_address    <= {req_addr[31:2], 2'b00};
                            avm_read       <= is_load(op_in);
                            avm_write      <= is_store(op_in);
                            avm_byteenable <= st_be;
                            avm_writedata  <= st_wdata;
                        end
                    end
                end
                ST_BUS: begin
                    if (!avm_waitrequest) begin
                        state     <= ST_RESP;
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b0;
                        rsp_wen   <= is_load(op_q);
                        rsp_wdata <= is_load(op_q) ? load_result : 32'h0;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_wen   <= 1'b0;
                    rsp_fault <= 1'b0;
                    rsp_wdata <= 32'h0;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// operations checked against a byte-level behavioural model.
module tb_mem_access_ctrl;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_store_data;
    logic [31:0] req_rt_old;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic        rsp_wen;
    logic [31:0] rsp_wdata;
    logic        rsp_fault;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_store_data  (req_store_data),
        .req_rt_old      (req_rt_old),
        .req_ready       (req_ready),
        .stall           (stall),
        .rsp_valid       (rsp_valid),
        .rsp_wen         (rsp_wen),
        .rsp_wdata       (rsp_wdata),
        .rsp_fault       (rsp_fault),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    // What one operation looked like from the outside.
    typedef struct {
        int          rsp_cyc;
        int          strobes;
        logic        wen;
        logic        fault;
        logic [31:0] wdata;
        logic        saw_read;
        logic        saw_write;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        stable;
        logic        hs_ok;
        logic        ready_after;
        logic        pulse_after;
        logic        stall_after;
    } obs_t;

    // ---------------- behavioural reference model ----------------
    function automatic int op_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB, OP_LWL, OP_LWR: return 1;
            OP_LH, OP_LHU, OP_SH:                 return 2;
            OP_LW, OP_SW:                         return 4;
            default:                              return 0;
        endcase
    endfunction

    function automatic logic m_load(input logic [3:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
    endfunction

    function automatic logic m_store(input logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Reserved codes and accesses not naturally aligned to their size fault.
    function automatic logic m_fault(input logic [3:0] op, input int off);
        int n = op_size(op);
        if (n == 0) return 1'b1;
        return (off % n) != 0;
    endfunction

    function automatic logic [31:0] m_load_val(input logic [3:0] op, input int off,
                                               input logic [31:0] rd, input logic [31:0] rt);
        logic [7:0]  rb [4];
        logic [7:0]  tb [4];
        logic [7:0]  res [4];
        logic [15:0] h;
        for (int k = 0; k < 4; k++) begin
            rb[k] = rd[8*k +: 8];
            tb[k] = rt[8*k +: 8];
        end
        h = {rb[2*(off/2)+1], rb[2*(off/2)]};
        case (op)
            OP_LB:  return int'($signed(rb[off]));
            OP_LBU: return {24'h0, rb[off]};
            OP_LH:  return int'($signed(h));
            OP_LHU: return {16'h0, h};
            OP_LWL: for (int k = 0; k < 4; k++) res[k] = (k >= 3 - off) ? rb[k - (3 - off)] : tb[k];
            OP_LWR: for (int k = 0; k < 4; k++) res[k] = (k < 4 - off) ? rb[k + off] : tb[k];
            default: return rd;
        endcase
        return {res[3], res[2], res[1], res[0]};
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input int off);
        logic [3:0] be = 4'h0;
        if (!m_store(op)) return 4'b1111;
        for (int i = 0; i < op_size(op); i++) be[off + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [3:0] op, input logic [31:0] d);
        logic [31:0] r;
        int n = op_size(op);
        for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % n) +: 8];
        return r;
    endfunction

    // ---------------- driver / bus responder ----------------
    // Presents one request in the current cycle (cycle 0), answers the bus with
    // `waits` waitrequest cycles, and records what the controller did.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rt, input logic [31:0] rd, input int waits,
                          input logic hold, output obs_t o);
        int strobes = 0;
        o = '{default: 0};
        o.rsp_cyc = -1;
        o.stable  = 1'b1;
        o.hs_ok   = 1'b1;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_store_data = sdata; req_rt_old = rt;
        avm_waitrequest = 1'b0; avm_readdata = ~rd;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (req_ready !== (cyc == 0) || stall !== 1'b1) o.hs_ok = 1'b0;
            if (avm_read === 1'b1 || avm_write === 1'b1) begin
                strobes++;
                if (strobes == 1) begin
                    o.addr = avm_address; o.be = avm_byteenable; o.wd = avm_writedata;
                    o.saw_read = avm_read; o.saw_write = avm_write;
                end else if ({avm_address, avm_byteenable, avm_writedata, avm_read, avm_write} !==
                             {o.addr, o.be, o.wd, o.saw_read, o.saw_write}) begin
                    o.stable = 1'b0;
                end
                avm_waitrequest = (strobes <= waits);
                avm_readdata    = (strobes <= waits) ? $urandom : rd;
            end else begin
                avm_waitrequest = 1'b0;
                avm_readdata    = ~rd;
            end
            if (rsp_valid === 1'b1) begin
                o.rsp_cyc = cyc; o.wen = rsp_wen; o.fault = rsp_fault; o.wdata = rsp_wdata;
                break;
            end
            @(posedge clk);
            @(negedge clk);
            req_valid = hold;
            if (hold) begin
                req_op = 4'($urandom); req_addr = $urandom; req_store_data = $urandom; req_rt_old = $urandom;
            end
        end
        o.strobes = strobes;
        req_valid = 1'b0;
        avm_readdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        #1;
        o.ready_after = req_ready;
        o.pulse_after = rsp_valid;
        o.stall_after = stall;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0;
        req_store_data = 32'h0; req_rt_old = 32'h0; avm_readdata = 32'h0; avm_waitrequest = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if ({avm_read, avm_write, rsp_valid, rsp_wen, rsp_fault} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: got %b expected 00000", {avm_read, avm_write, rsp_valid, rsp_wen, rsp_fault}); end
        checks++; if (avm_byteenable !== 4'h0) begin errors++; $display("FAIL reset_be: got %h expected 0", avm_byteenable); end
        checks++; if ({avm_address, avm_writedata, rsp_wdata} !== 96'h0) begin
            errors++; $display("FAIL reset_data: got %h %h %h expected zeros", avm_address, avm_writedata, rsp_wdata); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_lw();
        obs_t o;
        run_op(OP_LW, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 0, 1'b0, o);
        checks++; if (o.rsp_cyc !== 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", o.rsp_cyc); end
        checks++; if (o.wen !== 1'b1 || o.fault !== 1'b0) begin errors++; $display("FAIL lw_wen_fault: got %b%b expected 10", o.wen, o.fault); end
        checks++; if (o.wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_wdata: got %h expected deadbeef", o.wdata); end
        checks++; if (o.addr !== 32'h100 || o.saw_read !== 1'b1 || o.be !== 4'hF) begin
            errors++; $display("FAIL lw_bus: got addr %h read %b be %h expected 100 1 f", o.addr, o.saw_read, o.be); end
        checks++; if (o.hs_ok !== 1'b1) begin errors++; $display("FAIL lw_handshake: got %b expected 1", o.hs_ok); end
        checks++; if ({o.ready_after, o.pulse_after, o.stall_after} !== 3'b100) begin
            errors++; $display("FAIL lw_after: got %b expected 100", {o.ready_after, o.pulse_after, o.stall_after}); end
    endtask

    task automatic test_byte_loads();
        obs_t o;
        run_op(OP_LB, 32'h103, 32'h0, 32'h0, 32'h80112233, 0, 1'b0, o);
        checks++; if (o.wdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext: got %h expected ffffff80", o.wdata); end
        run_op(OP_LBU, 32'h103, 32'h0, 32'h0, 32'h80112233, 0, 1'b0, o);
        checks++; if (o.wdata !== 32'h00000080) begin errors++; $display("FAIL lbu_zext: got %h expected 00000080", o.wdata); end
        run_op(OP_LH, 32'h102, 32'h0, 32'h0, 32'h80112233, 1, 1'b0, o);
        checks++; if (o.wdata !== 32'hFFFF8011) begin errors++; $display("FAIL lh_sext: got %h expected ffff8011", o.wdata); end
        run_op(OP_LHU, 32'h100, 32'h0, 32'h0, 32'h80118233, 0, 1'b0, o);
        checks++; if (o.wdata !== 32'h00008233) begin errors++; $display("FAIL lhu_zext: got %h expected 00008233", o.wdata); end
    endtask

    task automatic test_lwl_lwr();
        obs_t o;
        run_op(OP_LWL, 32'h101, 32'h0, 32'h11223344, 32'hAABBCCDD, 0, 1'b0, o);
        checks++; if (o.wdata !== 32'hCCDD3344) begin errors++; $display("FAIL lwl_merge: got %h expected ccdd3344", o.wdata); end
        run_op(OP_LWR, 32'h102, 32'h0, 32'h11223344, 32'hAABBCCDD, 0, 1'b0, o);
        checks++; if (o.wdata !== 32'h1122AABB) begin errors++; $display("FAIL lwr_merge: got %h expected 1122aabb", o.wdata); end
    endtask

    task automatic test_sh_wait();
        obs_t o;
        run_op(OP_SH, 32'h202, 32'h0000BEEF, 32'h0, 32'h0, 3, 1'b0, o);
        checks++; if (o.rsp_cyc !== 5) begin errors++; $display("FAIL sh_latency: got %0d expected 5", o.rsp_cyc); end
        checks++; if (o.strobes !== 4 || o.stable !== 1'b1) begin
            errors++; $display("FAIL sh_hold: got %0d cycles stable %b expected 4 1", o.strobes, o.stable); end
        checks++; if (o.addr !== 32'h200 || o.be !== 4'b1100 || o.wd !== 32'hBEEFBEEF) begin
            errors++; $display("FAIL sh_lanes: got %h %b %h expected 200 1100 beefbeef", o.addr, o.be, o.wd); end
        checks++; if (o.saw_write !== 1'b1 || o.saw_read !== 1'b0 || o.wen !== 1'b0) begin
            errors++; $display("FAIL sh_ctrl: got write %b read %b wen %b expected 1 0 0", o.saw_write, o.saw_read, o.wen); end
    endtask

    task automatic test_fault();
        obs_t o;
        run_op(OP_LW, 32'h101, 32'h0, 32'h0, 32'h12345678, 0, 1'b0, o);
        checks++; if (o.rsp_cyc !== 1 || o.fault !== 1'b1 || o.wen !== 1'b0) begin
            errors++; $display("FAIL lw_misaligned: got cyc %0d fault %b wen %b expected 1 1 0", o.rsp_cyc, o.fault, o.wen); end
        checks++; if (o.strobes !== 0) begin errors++; $display("FAIL fault_no_bus: got %0d strobes expected 0", o.strobes); end
        run_op(4'd12, 32'h400, 32'h0, 32'h0, 32'h0, 0, 1'b0, o);
        checks++; if (o.rsp_cyc !== 1 || o.fault !== 1'b1 || o.strobes !== 0) begin
            errors++; $display("FAIL reserved_op: got cyc %0d fault %b strobes %0d expected 1 1 0", o.rsp_cyc, o.fault, o.strobes); end
    endtask

    task automatic test_reset_mid_bus();
        logic saw_rsp = 1'b0;
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h300; req_store_data = 32'hCAFEF00D;
        avm_waitrequest = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (avm_write !== 1'b1) begin errors++; $display("FAIL rst_bus_strobe: got %b expected 1", avm_write); end
        @(posedge clk);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++; if (avm_write !== 1'b0) begin errors++; $display("FAIL rst_drop_write: got %b expected 0", avm_write); end
        @(negedge clk);
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
        end
        checks++; if (saw_rsp !== 1'b0) begin errors++; $display("FAIL rst_no_rsp: got %b expected 0", saw_rsp); end
        checks++; if (req_ready !== 1'b1 || avm_write !== 1'b0) begin
            errors++; $display("FAIL rst_idle: got ready %b write %b expected 1 0", req_ready, avm_write); end
    endtask

    task automatic test_random();
        logic [3:0] ops [12] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
                                 OP_SB, OP_SH, OP_SW, 4'd7, 4'd13};
        for (int n = 0; n < 60; n++) begin
            obs_t        o;
            logic [3:0]  op    = ops[$urandom_range(0, 11)];
            logic [31:0] addr  = $urandom;
            logic [31:0] sdata = $urandom;
            logic [31:0] rt    = $urandom;
            logic [31:0] rd    = $urandom;
            int          waits = $urandom_range(0, 3);
            logic        hold  = 1'($urandom_range(0, 1));
            int          off;
            logic        f;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            off = int'(addr[1:0]);
            f   = m_fault(op, off);
            run_op(op, addr, sdata, rt, rd, waits, hold, o);
            checks++; if (o.rsp_cyc !== (f ? 1 : 2 + waits)) begin
                errors++; $display("FAIL rnd_latency op %0d: got %0d expected %0d", op, o.rsp_cyc, f ? 1 : 2 + waits); end
            checks++; if (o.fault !== f || o.wen !== (m_load(op) && !f)) begin
                errors++; $display("FAIL rnd_flags op %0d off %0d: got fault %b wen %b expected %b %b", op, off, o.fault, o.wen, f, m_load(op) && !f); end
            checks++; if (o.strobes !== (f ? 0 : waits + 1) || o.stable !== 1'b1) begin
                errors++; $display("FAIL rnd_bus_hold op %0d: got %0d stable %b expected %0d 1", op, o.strobes, o.stable, f ? 0 : waits + 1); end
            checks++; if (o.hs_ok !== 1'b1 || {o.ready_after, o.pulse_after, o.stall_after} !== 3'b100) begin
                errors++; $display("FAIL rnd_handshake op %0d: got %b %b expected 1 100", op, o.hs_ok, {o.ready_after, o.pulse_after, o.stall_after}); end
            if (!f) begin
                checks++; if (o.addr !== {addr[31:2], 2'b00} || o.be !== m_be(op, off) ||
                              o.saw_read !== m_load(op) || o.saw_write !== m_store(op)) begin
                    errors++; $display("FAIL rnd_bus op %0d: got %h %b r%b w%b expected %h %b r%b w%b", op, o.addr, o.be,
                        o.saw_read, o.saw_write, {addr[31:2], 2'b00}, m_be(op, off), m_load(op), m_store(op)); end
            end
            if (!f && m_store(op)) begin
                checks++; if (o.wd !== m_wd(op, sdata)) begin
                    errors++; $display("FAIL rnd_writedata op %0d: got %h expected %h", op, o.wd, m_wd(op, sdata)); end
            end
            if (!f && m_load(op)) begin
                checks++; if (o.wdata !== m_load_val(op, off, rd, rt)) begin
                    errors++; $display("FAIL rnd_load op %0d off %0d: got %h expected %h", op, off, o.wdata, m_load_val(op, off, rd, rt)); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lw();
        test_byte_loads();
        test_lwl_lwr();
        test_sh_wait();
        test_fault();
        test_reset_mid_bus();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle load/store controller between the MIPS execute/writeback stages and the Avalon-style data memory bus. It accepts one memory operation at a time and drives the bus through the waitrequest handshake. It then formats read data for every load type, including LWL/LWR merges with the old rt value, and returns a register write value. It holds `stall` high so the core freezes until the access completes.

## Interface
Parameters:
- none (widths fixed at MIPS32)

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge
- `reset_n`  in  1  — asynchronous, active-low reset
- `req_valid`  in  1  — core presents a memory op
- `req_op`  in  4  — `mem_op_t`: LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW; other codes are reserved
- `req_addr`  in  32  — effective byte address
- `req_store_data`  in  32  — rt value for stores
- `req_rt_old`  in  32  — current rt value, merged by LWL/LWR
- `req_ready`  out  1  — high only in IDLE
- `stall`  out  1  — high from the accept cycle until the cycle `rsp_valid` is high, inclusive
- `rsp_valid`  out  1  — one-cycle completion pulse
- `rsp_wen`  out  1  — register write enable; loads only, never on fault
- `rsp_wdata`  out  32  — formatted load result
- `rsp_fault`  out  1  — address error; valid with `rsp_valid`
- `avm_address`  out  32  — word-aligned, `{req_addr[31:2],2'b00}`
- `avm_read`  out  1
- `avm_write`  out  1
- `avm_byteenable`  out  4
- `avm_writedata`  out  32
- `avm_readdata`  in  32
- `avm_waitrequest`  in  1

## Operation
- Byte order is little-endian: byte k sits at bits `[8k+7:8k]`. `off = req_addr[1:0]` is latched at accept.
- FSM states are IDLE, BUS and RESP.
- **IDLE**
  - Accept when `req_valid && req_ready`; latch op, addr, store data and rt_old.
  - If the access is misaligned, go to RESP with the fault flag set. Misaligned means LH/LHU/SH with `off[0]=1`, or LW/SW with `off!=0`. Reserved ops also take this path.
  - Otherwise go to BUS.
- **BUS**
  - Drive `avm_read` (loads) or `avm_write` (stores) from registered values.
  - Hold every bus output stable while `avm_waitrequest=1`.
  - On `waitrequest=0`, a load captures `avm_readdata` on that edge. Either way, go to RESP.
- **RESP**
  - Drive `rsp_valid=1`, `rsp_wen` = (load and not fault), and `rsp_fault`.
  - Return to IDLE.
- Read byteenable is always `4'b1111`.
- SB: byteenable `1<<off`; writedata = byte replicated ×4.
- SH: byteenable `4'b0011` (off 0) or `4'b1100` (off 2); writedata = halfword replicated ×2.
- SW: byteenable `4'b1111`.
- Load formatting, with rd = captured readdata:
  - LB / LBU: byte `off`, sign- or zero-extended.
  - LH / LHU: halfword `off[1]`, sign- or zero-extended.
  - LW: rd.
  - LWL: rd bytes `[off:0]` fill the top `off+1` bytes; rt_old keeps its low `3-off` bytes.
  - LWR: rd bytes `[3:off]` fill the low `4-off` bytes; rt_old keeps its high `off` bytes.
- Requests arriving while not IDLE are ignored.

## Timing
- Reset values (immediate, asynchronous): state IDLE; `avm_read`, `avm_write`, `rsp_valid`, `rsp_wen`, `rsp_fault` = 0; `avm_byteenable` = 0; `avm_address`, `avm_writedata`, `rsp_wdata` = 0; `req_ready` = 1; `stall` = 0.
- Zero-wait access: accept at cycle 0, bus strobe at cycle 1, `rsp_valid` at cycle 2, `req_ready` high again at cycle 3.
- Each cycle of `waitrequest=1` adds one cycle of latency.
- Fault path: `rsp_valid` at cycle 1 and no bus strobe is ever asserted.
- `rsp_wdata` is valid only while `rsp_valid=1`; it is registered, not combinational from `avm_readdata`.
- `reset_n` low in mid-BUS drops the strobe the same cycle and discards the operation; no `rsp_valid` follows.

## Structure
- Package `mips_mem_pkg`: `mem_op_t` enum, `ctrl_state_t` enum, `is_load()` and `is_store()` helper functions.
- Sub-module `load_align`: purely combinational. Maps (op, off, rd, rt_old) to the 32-bit result and is instantiated once. FSM, latches and store lane steering stay in the top.

## Test plan
- LW at 0x100, readdata 0xDEADBEEF, waitrequest 0 → `rsp_valid` at cycle 2, `rsp_wen=1`, `rsp_wdata=0xDEADBEEF`, `avm_address=0x100`.
- LB at 0x103, readdata 0x80112233 → `rsp_wdata=0xFFFFFF80`; LBU at the same address → `0x00000080`.
- LWL at 0x101, rd 0xAABBCCDD, rt_old 0x11223344 → `0xCCDD3344`. LWR at 0x102, same data → `0x1122AABB`.
- SH at 0x202, data 0x0000BEEF, waitrequest high for 3 cycles → address/writedata/byteenable `4'b1100` held stable for 4 cycles, writedata `0xBEEFBEEF`, `rsp_valid` at cycle 5, `rsp_wen=0`.
- LW at 0x101 → `rsp_fault=1`, `rsp_wen=0` at cycle 1, no `avm_read` seen.
- `reset_n` pulled low during the second waitrequest cycle of an SW → `avm_write` is 0 immediately; after release the block is in IDLE with `req_ready=1` and no `rsp_valid`.
